// File: rtl/lcd_content.sv
// lcd_content: HD44780 write-only controller for the voting-machine display.
// Sends the init bytes once, then refreshes both 16-column lines forever,
// computing each character from the live inputs as it is sent.
module lcd_content #(
  parameter int EN_CYCLES  = 16,
  parameter int DLY_CYCLES = 262142
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [2:0] estado,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] c1Dez,
  input  logic [3:0] c1Uni,
  input  logic [3:0] c2Dez,
  input  logic [3:0] c2Uni,
  input  logic [3:0] c3Dez,
  input  logic [3:0] c3Uni,
  input  logic [3:0] c4Dez,
  input  logic [3:0] c4Uni,
  input  logic [3:0] nDez,
  input  logic [3:0] nUni,
  input  logic [3:0] tDez,
  input  logic [3:0] tUni,
  input  logic [3:0] cadVencedr1,
  input  logic [3:0] cadVencedr2,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // Byte positions: 0-3 init, 4 line-1 address, 5-20 line 1,
  // 21 line-2 address, 22-37 line 2, then back to 4.
  localparam logic [5:0] POS_L1_CMD = 6'd4;
  localparam logic [5:0] POS_L1     = 6'd5;
  localparam logic [5:0] POS_L2_CMD = 6'd21;
  localparam logic [5:0] POS_L2     = 6'd22;
  localparam logic [5:0] POS_LAST   = 6'd37;

  localparam logic [31:0] EN_LAST  = 32'(EN_CYCLES - 1);
  localparam logic [31:0] DLY_LAST = 32'(DLY_CYCLES - 1);

  // PH_START: just out of reset, nothing presented yet.
  // PH_SETUP: byte on the bus with EN low (cycle 0).
  // PH_PULSE: EN high. PH_GAP: EN low, waiting for the LCD to finish.
  typedef enum logic [1:0] {PH_START, PH_SETUP, PH_PULSE, PH_GAP} phase_t;

  phase_t      stateQ, stateD;
  logic [31:0] cntQ, cntD;
  logic [5:0]  posQ, posD;
  logic [7:0]  dataQ, dataD;
  logic        rsQ, rsD;
  logic        enQ, enD;

  logic [5:0]   loadPos;
  logic         loadLine2;
  logic [3:0]   loadCol;
  logic [127:0] lineText;
  logic         aEn, bEn;
  logic [3:0]   aCol, bCol;
  logic [3:0]   aTens, aUnits, bTens, bUnits;
  logic [7:0]   charByte;
  logic [7:0]   loadByte;
  logic         loadRs;

  // Digits 0-9 become ASCII; anything else (including unknown) shows '-'.
  function automatic logic [7:0] digitChar(input logic [3:0] v);
    if (v <= 4'd9) digitChar = 8'h30 + {4'h0, v};
    else           digitChar = 8'h2D;
  endfunction

  // Work out which byte position is loaded next and where it lands on screen.
  always_comb begin
    loadPos = 6'd0;
    if (stateQ != PH_START) begin
      if (posQ == POS_LAST) loadPos = POS_L1_CMD;
      else                  loadPos = posQ + 6'd1;
    end
    loadLine2 = (loadPos >= POS_L2_CMD);
    if (loadLine2) loadCol = 4'(loadPos - POS_L2);
    else           loadCol = 4'(loadPos - POS_L1);
  end

  // Fixed screen text plus up to two two-digit fields per line.
  always_comb begin
    lineText = {16{8'h20}};
    aEn = 1'b0; aCol = 4'd0; aTens = 4'd0; aUnits = 4'd0;
    bEn = 1'b0; bCol = 4'd0; bTens = 4'd0; bUnits = 4'd0;
    case ({loadLine2, estado})
      4'b0_000: lineText = "URNA ELETRONICA ";
      4'b0_001: lineText = "DIGITE O VOTO   ";
      4'b0_010: lineText = "CONFIRMA VOTO?  ";
      4'b0_011: lineText = "VOTO CONFIRMADO ";
      4'b0_100: lineText = "APURACAO        ";
      4'b0_101: lineText = "VENCEDOR:       ";
      4'b0_110: begin
        lineText = "C10:   C13:     ";
        aEn = 1'b1; aCol = 4'd4;  aTens = c1Dez; aUnits = c1Uni;
        bEn = 1'b1; bCol = 4'd11; bTens = c2Dez; bUnits = c2Uni;
      end
      4'b0_111: begin
        lineText = "NULOS:          ";
        aEn = 1'b1; aCol = 4'd6; aTens = nDez; aUnits = nUni;
      end
      4'b1_000: lineText = "APERTE KEY0     ";
      4'b1_001,
      4'b1_010: begin
        lineText = "NUMERO:         ";
        aEn = 1'b1; aCol = 4'd8; aTens = bcd1; aUnits = bcd2;
      end
      4'b1_011: lineText = "OBRIGADO        ";
      4'b1_100: lineText = "APERTE KEY0     ";
      4'b1_101: begin
        lineText = "CANDIDATO       ";
        aEn = 1'b1; aCol = 4'd10; aTens = cadVencedr1; aUnits = cadVencedr2;
      end
      4'b1_110: begin
        lineText = "C17:   C51:     ";
        aEn = 1'b1; aCol = 4'd4;  aTens = c3Dez; aUnits = c3Uni;
        bEn = 1'b1; bCol = 4'd11; bTens = c4Dez; bUnits = c4Uni;
      end
      default: begin
        lineText = "TOTAL:          ";
        aEn = 1'b1; aCol = 4'd6; aTens = tDez; aUnits = tUni;
      end
    endcase
  end

  // Pick the character at the load column, overlaying any digit field.
  always_comb begin
    charByte = lineText[{~loadCol, 3'b000} +: 8];
    if (aEn && loadCol == aCol)         charByte = digitChar(aTens);
    if (aEn && loadCol == aCol + 4'd1)  charByte = digitChar(aUnits);
    if (bEn && loadCol == bCol)         charByte = digitChar(bTens);
    if (bEn && loadCol == bCol + 4'd1)  charByte = digitChar(bUnits);
  end

  // Command bytes at fixed positions, characters everywhere else.
  always_comb begin
    loadByte = charByte;
    loadRs   = 1'b1;
    case (loadPos)
      6'd0:       begin loadByte = 8'h38; loadRs = 1'b0; end
      6'd1:       begin loadByte = 8'h0C; loadRs = 1'b0; end
      6'd2:       begin loadByte = 8'h01; loadRs = 1'b0; end
      6'd3:       begin loadByte = 8'h06; loadRs = 1'b0; end
      POS_L1_CMD: begin loadByte = 8'h80; loadRs = 1'b0; end
      POS_L2_CMD: begin loadByte = 8'hC0; loadRs = 1'b0; end
      default:    ;
    endcase
  end

  // Per-byte timing: present, strobe EN, wait out the gap, load the next byte.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    posD   = posQ;
    dataD  = dataQ;
    rsD    = rsQ;
    enD    = enQ;
    case (stateQ)
      PH_START: begin
        posD   = loadPos;
        dataD  = loadByte;
        rsD    = loadRs;
        enD    = 1'b0;
        stateD = PH_SETUP;
      end
      PH_SETUP: begin
        enD    = 1'b1;
        cntD   = 32'd0;
        stateD = PH_PULSE;
      end
      PH_PULSE: begin
        if (cntQ == EN_LAST) begin
          enD    = 1'b0;
          cntD   = 32'd0;
          stateD = PH_GAP;
        end else begin
          cntD = cntQ + 32'd1;
        end
      end
      default: begin
        if (cntQ == DLY_LAST) begin
          posD   = loadPos;
          dataD  = loadByte;
          rsD    = loadRs;
          cntD   = 32'd0;
          stateD = PH_SETUP;
        end else begin
          cntD = cntQ + 32'd1;
        end
      end
    endcase
  end

  // State and output registers; reset drops the bus and restarts from init.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ <= PH_START;
      cntQ   <= 32'd0;
      posQ   <= 6'd0;
      dataQ  <= 8'h00;
      rsQ    <= 1'b0;
      enQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      posQ   <= posD;
      dataQ  <= dataD;
      rsQ    <= rsD;
      enQ    <= enD;
    end
  end

  assign LCD_DATA = dataQ;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = enQ;
  assign LCD_RS   = rsQ;

endmodule

// File: tb/tb_lcd_content.sv
// tb_lcd_content: scoreboard bench for the LCD controller. Stimulus pushes the
// expected byte stream; a monitor pops and checks each byte as EN rises.
module tb_lcd_content;

  localparam int EN_CYC = 16;
  localparam int DLY    = 4;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [2:0] estado;
  logic [3:0] bcd1, bcd2;
  logic [3:0] c1Dez, c1Uni, c2Dez, c2Uni, c3Dez, c3Uni, c4Dez, c4Uni;
  logic [3:0] nDez, nUni, tDez, tUni;
  logic [3:0] cadVencedr1, cadVencedr2;
  wire  [7:0] LCD_DATA;
  logic       LCD_RW, LCD_EN, LCD_RS;

  typedef struct {
    logic [7:0] data;
    logic       rs;
  } exp_t;

  exp_t expQ[$];
  exp_t popped;
  int   checks = 0;
  int   errors = 0;
  int   byteCount = 0;
  bit   abortPulse = 1'b0;

  lcd_content #(.EN_CYCLES(EN_CYC), .DLY_CYCLES(DLY)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .estado(estado),
    .bcd1(bcd1), .bcd2(bcd2),
    .c1Dez(c1Dez), .c1Uni(c1Uni), .c2Dez(c2Dez), .c2Uni(c2Uni),
    .c3Dez(c3Dez), .c3Uni(c3Uni), .c4Dez(c4Dez), .c4Uni(c4Uni),
    .nDez(nDez), .nUni(nUni), .tDez(tDez), .tUni(tUni),
    .cadVencedr1(cadVencedr1), .cadVencedr2(cadVencedr2),
    .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] digitOf(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    return 8'h2D;
  endfunction

  // Reference screen text, built from the current input values.
  function automatic string screenText(input int scr, input bit line2);
    string s;
    case (scr)
      0: s = line2 ? "APERTE KEY0" : "URNA ELETRONICA";
      1: s = line2 ? $sformatf("NUMERO: %c%c", digitOf(bcd1), digitOf(bcd2)) : "DIGITE O VOTO";
      2: s = line2 ? $sformatf("NUMERO: %c%c", digitOf(bcd1), digitOf(bcd2)) : "CONFIRMA VOTO?";
      3: s = line2 ? "OBRIGADO" : "VOTO CONFIRMADO";
      4: s = line2 ? "APERTE KEY0" : "APURACAO";
      5: s = line2 ? $sformatf("CANDIDATO %c%c", digitOf(cadVencedr1), digitOf(cadVencedr2))
                   : "VENCEDOR:";
      6: s = line2 ? $sformatf("C17:%c%c C51:%c%c", digitOf(c3Dez), digitOf(c3Uni),
                               digitOf(c4Dez), digitOf(c4Uni))
                   : $sformatf("C10:%c%c C13:%c%c", digitOf(c1Dez), digitOf(c1Uni),
                               digitOf(c2Dez), digitOf(c2Uni));
      default: s = line2 ? $sformatf("TOTAL:%c%c", digitOf(tDez), digitOf(tUni))
                         : $sformatf("NULOS:%c%c", digitOf(nDez), digitOf(nUni));
    endcase
    while (s.len() < 16) s = {s, " "};
    return s;
  endfunction

  task automatic pushByte(input logic [7:0] d, input logic rs);
    exp_t e;
    e.data = d;
    e.rs   = rs;
    expQ.push_back(e);
  endtask

  task automatic pushInit();
    pushByte(8'h38, 1'b0);
    pushByte(8'h0C, 1'b0);
    pushByte(8'h01, 1'b0);
    pushByte(8'h06, 1'b0);
  endtask

  // Expected bytes for columns fromCol..toCol of one line (address byte first).
  task automatic pushLine(input bit line2, input int fromCol, input int toCol);
    string s;
    s = screenText(int'(estado), line2);
    if (fromCol == 0) pushByte(line2 ? 8'hC0 : 8'h80, 1'b0);
    for (int col = fromCol; col <= toCol; col++) pushByte(8'(s.getc(col)), 1'b1);
  endtask

  task automatic pushFrame();
    pushLine(1'b0, 0, 15);
    pushLine(1'b1, 0, 15);
  endtask

  task automatic applyStimulus(input logic [2:0] scr);
    estado = scr;
  endtask

  task automatic waitBytes(input int target);
    int budget = 0;
    while (byteCount < target && budget < 5000) begin
      @(negedge iCLK);
      budget++;
    end
    if (byteCount < target) checkOutput("byte_timeout", 32'(byteCount), 32'(target));
  endtask

  // Monitor: on each EN rise pop and compare; on EN fall check width and hold.
  logic       prevEn = 1'b0;
  int         width = 0;
  logic [7:0] heldData;
  logic       heldRs;
  always @(negedge iCLK) begin
    if (LCD_EN && !prevEn) begin
      byteCount++;
      heldData = LCD_DATA;
      heldRs   = LCD_RS;
      width    = 1;
      checkOutput("rw_low", 32'(LCD_RW), 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h rs %0d, expected none", LCD_DATA, LCD_RS);
      end else begin
        popped = expQ.pop_front();
        checkOutput($sformatf("byte%0d_data", byteCount), 32'(LCD_DATA), 32'(popped.data));
        checkOutput($sformatf("byte%0d_rs", byteCount), 32'(LCD_RS), 32'(popped.rs));
      end
    end else if (LCD_EN) begin
      width++;
    end else if (prevEn) begin
      if (!abortPulse) begin
        checkOutput("en_width", 32'(width), 32'(EN_CYC));
        checkOutput("hold_bus", {23'd0, LCD_DATA, LCD_RS}, {23'd0, heldData, heldRs});
      end
      abortPulse = 1'b0;
    end
    prevEn = LCD_EN;
  end

  // Runaway guard.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios, each one a full frame or a deliberate interruption.
  initial begin
    iRST_N = 1'b0;
    estado = 3'd1; bcd1 = 4'd1; bcd2 = 4'd3;
    c1Dez = 4'd0; c1Uni = 4'd5; c2Dez = 4'd2; c2Uni = 4'd7;
    c3Dez = 4'd9; c3Uni = 4'd9; c4Dez = 4'd1; c4Uni = 4'd2;
    nDez = 4'd0; nUni = 4'd4; tDez = 4'd3; tUni = 4'd8;
    cadVencedr1 = 4'hF; cadVencedr2 = 4'hA;

    repeat (3) @(negedge iCLK);
    checkOutput("reset_en", 32'(LCD_EN), 32'd0);
    checkOutput("reset_rs", 32'(LCD_RS), 32'd0);
    checkOutput("reset_data", 32'(LCD_DATA), 32'd0);
    checkOutput("reset_rw", 32'(LCD_RW), 32'd0);

    // Init then a typed-vote frame: line 2 "NUMERO: 13".
    pushInit();
    pushFrame();
    iRST_N = 1'b1;
    waitBytes(38);

    // Candidate tallies: "C10:05 C13:27" / "C17:99 C51:12".
    applyStimulus(3'd6);
    pushFrame();
    waitBytes(72);

    // Out-of-range winner digits show as "--".
    applyStimulus(3'd5);
    pushFrame();
    waitBytes(106);

    // Welcome screen, then switch to the null/total screen between frames.
    applyStimulus(3'd0);
    pushFrame();
    waitBytes(140);
    applyStimulus(3'd7);
    pushFrame();
    waitBytes(174);

    // Screen change after line-1 column 3 takes effect from column 4 on.
    applyStimulus(3'd4);
    pushLine(1'b0, 0, 3);
    waitBytes(179);
    applyStimulus(3'd2);
    pushLine(1'b0, 4, 15);
    pushLine(1'b1, 0, 15);
    waitBytes(208);

    // Reset in the middle of an EN pulse, then init restarts.
    pushLine(1'b0, 0, 0);
    waitBytes(209);
    @(posedge iCLK);
    #3;
    abortPulse = 1'b1;
    iRST_N = 1'b0;
    #1;
    checkOutput("abort_en", 32'(LCD_EN), 32'd0);
    checkOutput("abort_data", 32'(LCD_DATA), 32'd0);
    checkOutput("abort_rs", 32'(LCD_RS), 32'd0);
    expQ.delete();
    pushInit();
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    waitBytes(213);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_content.md
LCD_CONTENT -- requirements
Module: lcd_content

Interface
REQ-001 SHALL have parameter EN_CYCLES, default 16, meaning the LCD_EN high-pulse width in iCLK cycles.
REQ-002 SHALL have parameter DLY_CYCLES, default 262142, meaning the idle gap after each byte (about 5.2 ms at 50 MHz); the bench may override it to a small value.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock.
REQ-004 SHALL have port iRST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port estado, input, 3 bits: screen select 0-7.
REQ-006 SHALL have ports bcd1 and bcd2, input, 4 bits each: typed vote, tens digit and units digit.
REQ-007 SHALL have ports c1Dez, c1Uni, c2Dez, c2Uni, c3Dez, c3Uni, c4Dez, c4Uni, input, 4 bits each: candidate 10/13/17/51 counts, tens and units.
REQ-008 SHALL have ports nDez, nUni, tDez, tUni, input, 4 bits each: null-vote count and total-vote count, tens and units.
REQ-009 SHALL have ports cadVencedr1 and cadVencedr2, input, 4 bits each: winner number, tens and units.
REQ-010 SHALL have port LCD_DATA, inout, 8 bits: HD44780 data bus, always driven (write-only use).
REQ-011 SHALL have ports LCD_RW, LCD_EN and LCD_RS, output, 1 bit each: LCD_RW is 0 = write, LCD_EN is the strobe, LCD_RS is 0 = command, 1 = data.

Function
REQ-012 LCD_RW SHALL be constant 0.
REQ-013 The controller SHALL issue the init bytes in order 0x38, 0x0C, 0x01, 0x06, all with RS=0.
REQ-014 After init, the controller SHALL refresh forever:
- 0x80 (RS=0), then 16 line-1 characters (RS=1);
- 0xC0 (RS=0), then 16 line-2 characters (RS=1);
- repeat from 0x80.
REQ-015 Per byte, the controller SHALL:
- cycle 0: drive LCD_DATA/LCD_RS, LCD_EN=0;
- cycles 1..EN_CYCLES: LCD_EN=1;
- then LCD_EN=0 for DLY_CYCLES cycles before the next byte.
REQ-016 LCD_DATA and LCD_RS SHALL stay stable throughout the EN pulse and the following gap.
REQ-017 Each character SHALL be computed from the inputs sampled in cycle 0 of its own transfer; input changes SHALL appear on the next refresh with no further handshake.
REQ-018 A digit 0-9 SHALL encode as 0x30+value; any value above 9, or X/Z, SHALL encode as '-' (0x2D).
REQ-019 Screen text per estado SHALL be as follows, 16 columns per line, left-aligned, space padded (0x20), dd = two digits per REQ-018:
- 0: "URNA ELETRONICA" / "APERTE KEY0"
- 1: "DIGITE O VOTO" / "NUMERO: dd" (bcd1, bcd2)
- 2: "CONFIRMA VOTO?" / "NUMERO: dd" (bcd1, bcd2)
- 3: "VOTO CONFIRMADO" / "OBRIGADO"
- 4: "APURACAO" / "APERTE KEY0"
- 5: "VENCEDOR:" / "CANDIDATO dd" (cadVencedr1, cadVencedr2)
- 6: "C10:dd C13:dd" / "C17:dd C51:dd"
- 7: "NULOS:dd" / "TOTAL:dd"
REQ-020 A mid-line estado change SHALL make the remaining characters of that line use the new screen.

Reset
REQ-021 While iRST_N=0, outputs SHALL be LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, LCD_RW=0.
REQ-022 While iRST_N=0, all counters and sequence indices SHALL clear asynchronously.
REQ-023 On the first iCLK after iRST_N rises, the controller SHALL start init byte 0x38.
REQ-024 Reset asserted mid-transfer or mid-refresh SHALL abort immediately and restart from init.

Verification
REQ-025 Scenario: DLY_CYCLES=4, reset, then release -> first four EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0, and each pulse lasts exactly 16 cycles.
REQ-026 Scenario: estado=1, bcd1=1, bcd2=3 -> after 0xC0, line 2 bytes are "NUMERO: 13", i.e. columns 9-10 = 0x31, 0x33, then six 0x20.
REQ-027 Scenario: estado=6, c1Dez=0, c1Uni=5, c4Dez=1, c4Uni=2 -> line 1 columns 5-6 = 0x30, 0x35; line 2 columns 12-13 = 0x31, 0x32.
REQ-028 Scenario: estado=5, cadVencedr1=4'hF, cadVencedr2=X -> line 2 reads "CANDIDATO --" (0x2D, 0x2D).
REQ-029 Scenario: estado switched 0->7 between frames -> next frame line 1 is "NULOS:dd" with nDez/nUni digits.
REQ-030 Scenario: iRST_N pulsed low while LCD_EN=1 -> LCD_EN falls with no clock edge, and after release the next byte is 0x38.
